// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, samples the
// synchronised active-low rows at the end of each column dwell, keeps the first
// pressed key of each full scan and debounces that result over several scans.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,  // cycles each column is driven, >= 4
  parameter int DEBOUNCE = 4      // identical full scans needed to change key, >= 1
) (
  input  logic       clk,
  input  logic       rst,         // asynchronous, active-low
  input  logic [3:0] row,         // active-low row sense, asynchronous to clk
  output logic [3:0] col,         // active-low one-hot column drive
  output logic [4:0] key,         // 5'h00..5'h0F hex key, 5'h10 none
  output logic       key_stb      // one-cycle pulse on a new non-none key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
  localparam logic [4:0]    KEY_NONE   = 5'h10;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } state_t;

  // Physical layout of the keypad: code of the key at (row r, column c).
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'h0:    code = 5'h01;
      4'h1:    code = 5'h02;
      4'h2:    code = 5'h03;
      4'h3:    code = 5'h0A;
      4'h4:    code = 5'h04;
      4'h5:    code = 5'h05;
      4'h6:    code = 5'h06;
      4'h7:    code = 5'h0B;
      4'h8:    code = 5'h07;
      4'h9:    code = 5'h08;
      4'hA:    code = 5'h09;
      4'hB:    code = 5'h0C;
      4'hC:    code = 5'h0E;
      4'hD:    code = 5'h00;
      4'hE:    code = 5'h0F;
      4'hF:    code = 5'h0D;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Active-low one-hot column pattern for a scan state.
  function automatic logic [3:0] col_drive(input state_t s);
    logic [3:0] drv;
    case (s)
      COL0:    drv = 4'b1110;
      COL1:    drv = 4'b1101;
      COL2:    drv = 4'b1011;
      COL3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_s;
  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_col;
  logic [4:0]    r_acc;
  logic [4:0]    r_prev;
  logic [SW-1:0] r_stable;
  logic [4:0]    r_key;
  logic          r_stb;

  logic          w_sample;
  logic          w_scan_done;
  logic [4:0]    w_col_code;
  logic [4:0]    w_acc_next;
  logic [SW-1:0] w_stable_next;
  logic          w_accept;

  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_scan_done = w_sample && (r_state == COL3);

  // Two-flop synchroniser; idle rows (all high) are the reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 4'hF;
      r_row_s    <= 4'hF;
    end else begin
      r_row_meta <= row;
      r_row_s    <= r_row_meta;
    end
  end

  // Scan state register and dwell counter; the state advances on the sample cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COL0;
      r_dwell <= '0;
      r_col   <= 4'b1110;
    end else begin
      r_state <= w_state_next;
      r_col   <= col_drive(w_state_next);
      if (w_sample) begin
        r_dwell <= '0;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Next scan state: round-robin over the four columns, one step per dwell.
  always_comb begin
    w_state_next = r_state;
    if (w_sample) begin
      case (r_state)
        COL0:    w_state_next = COL1;
        COL1:    w_state_next = COL2;
        COL2:    w_state_next = COL3;
        COL3:    w_state_next = COL0;
        default: w_state_next = COL0;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Lowest-numbered pressed row in the currently driven column.
  always_comb begin
    w_col_code = KEY_NONE;
    if (!r_row_s[0]) begin
      w_col_code = key_code(2'd0, r_state);
    end else if (!r_row_s[1]) begin
      w_col_code = key_code(2'd1, r_state);
    end else if (!r_row_s[2]) begin
      w_col_code = key_code(2'd2, r_state);
    end else if (!r_row_s[3]) begin
      w_col_code = key_code(2'd3, r_state);
    end else begin
      w_col_code = KEY_NONE;
    end
  end

  // Accumulator after this column's sample, and the debounce count it would produce.
  always_comb begin
    w_acc_next    = r_acc;
    w_stable_next = r_stable;
    if (r_acc != KEY_NONE) begin
      w_acc_next = r_acc;
    end else begin
      w_acc_next = w_col_code;
    end
    if (w_acc_next != r_prev) begin
      w_stable_next = SW'(1);
    end else if (r_stable == STABLE_MAX) begin
      w_stable_next = STABLE_MAX;
    end else begin
      w_stable_next = r_stable + SW'(1);
    end
  end

  assign w_accept = w_scan_done && (w_stable_next == STABLE_MAX) && (w_acc_next != r_key);

  // Per-scan accumulator: holds the first pressed key, cleared after column 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= KEY_NONE;
    end else if (w_scan_done) begin
      r_acc <= KEY_NONE;
    end else if (w_sample) begin
      r_acc <= w_acc_next;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Debounce history: previous scan result and how many scans in a row matched it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= KEY_NONE;
      r_stable <= '0;
    end else if (w_scan_done) begin
      r_prev   <= w_acc_next;
      r_stable <= w_stable_next;
    end else begin
      r_prev   <= r_prev;
      r_stable <= r_stable;
    end
  end

  // Output key register and strobe; the strobe only marks real keys, never release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key <= KEY_NONE;
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_accept && (w_acc_next != KEY_NONE);
      if (w_accept) begin
        r_key <= w_acc_next;
      end else begin
        r_key <= r_key;
      end
    end
  end

  assign col     = r_col;
  assign key     = r_key;
  assign key_stb = r_stb;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle scan).
// A small keypad model closes row r when key (r,c) is pressed and column c is driven.
module tb_keypad_scanner;

  localparam logic [4:0] KEY_NONE = 5'h10;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] key;
  logic       key_stb;

  logic [3:0] press [0:3];  // press[r][c] = key at row r, column c held down

  int n_pass;
  int n_total;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .col     (col),
    .key     (key),
    .key_stb (key_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad contact model: a row is pulled low through any pressed key in a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(press[r] & ~col);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_press();
    for (int r = 0; r < 4; r++) press[r] = 4'b0000;
  endtask

  // Pulse reset; on return we sit at cycle 0 of a fresh scan (dwell 0, column 0).
  task automatic reset_start();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Step negedge by negedge until key equals exp; counts strobes seen up to and including that cycle.
  task automatic run_until(input logic [4:0] exp, input int maxc,
                           output int found, output int nstb, output logic stb_at);
    found  = -1;
    nstb   = 0;
    stb_at = 1'b0;
    for (int i = 0; i <= maxc; i++) begin
      if (key_stb === 1'b1) nstb++;
      if (key === exp) begin
        found  = i;
        stb_at = key_stb;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int         found;
    int         nstb;
    logic       stb_at;
    int         bad;
    int         nst;
    logic [3:0] one;
    logic [3:0] exp_col;

    n_pass  = 0;
    n_total = 0;
    one     = 4'b0001;
    rst     = 1'b0;
    clear_press();

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_col", {28'd0, col}, {28'd0, 4'b1110});
    chk("reset_key", {27'd0, key}, {27'd0, KEY_NONE});
    chk("reset_stb", {31'd0, key_stb}, 32'd0);

    // Idle scan: each column held 4 cycles, key none, no strobe
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(one << ((i / 4) % 4));
      chk("idle_scan", {22'd0, col, key, key_stb}, {22'd0, exp_col, KEY_NONE, 1'b0});
      @(negedge clk);
    end

    // Key 6 (row1/col2) held from cycle 0: accepted after the second scan, at cycle 32
    clear_press();
    press[1] = 4'b0100;
    reset_start();
    run_until(5'h06, 60, found, nstb, stb_at);
    chk("k6_latency", found, 32);
    chk("k6_stb_aligned", {31'd0, stb_at}, 32'd1);
    chk("k6_stb_count", nstb, 1);
    bad = 0;
    nst = 0;
    repeat (200) begin
      @(negedge clk);
      if (key_stb !== 1'b0) nst++;
      if (key !== 5'h06) bad++;
    end
    chk("k6_hold_stb", nst, 0);
    chk("k6_hold_key", bad, 0);

    // Release at the start of column 2: two empty scans bring key back to none
    press[1] = 4'b0000;
    run_until(KEY_NONE, 51, found, nstb, stb_at);
    chk("release_latency", found, 24);
    chk("release_stb", nstb, 0);

    // Keys 1 and 7 in the same column: lower row wins
    clear_press();
    press[0] = 4'b0001;
    press[2] = 4'b0001;
    reset_start();
    run_until(5'h01, 60, found, nstb, stb_at);
    chk("multi_1_7", found, 32);
    chk("multi_1_7_stb", nstb, 1);

    // Key 0 (col1) and key A (col3): earlier column wins
    clear_press();
    press[3] = 4'b0010;
    press[0] = 4'b1000;
    reset_start();
    run_until(5'h00, 60, found, nstb, stb_at);
    chk("multi_0_a", found, 32);
    chk("multi_0_a_stb", {31'd0, stb_at}, 32'd1);

    // Bounce: the press flips once per full scan, so consecutive scans never agree
    clear_press();
    reset_start();
    bad = 0;
    nst = 0;
    for (int i = 0; i < 300; i++) begin
      press[0] = (((i / 16) % 2) == 0) ? 4'b0001 : 4'b0000;
      if (key !== KEY_NONE) bad++;
      if (key_stb !== 1'b0) nst++;
      @(negedge clk);
    end
    chk("bounce_key", bad, 0);
    chk("bounce_stb", nst, 0);

    // Key 6 accepted, then switched directly to key D
    clear_press();
    press[1] = 4'b0100;
    reset_start();
    run_until(5'h06, 60, found, nstb, stb_at);
    chk("chg_k6", found, 32);
    @(negedge clk);
    press[1] = 4'b0000;
    press[3] = 4'b1000;
    run_until(5'h0D, 60, found, nstb, stb_at);
    chk("chg_kd_latency", found, 31);
    chk("chg_kd_stb_count", nstb, 1);
    chk("chg_kd_stb_aligned", {31'd0, stb_at}, 32'd1);

    // Reset mid-hold acts immediately, then key D is re-acquired with a new strobe
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_key", {27'd0, key}, {27'd0, KEY_NONE});
    chk("midrst_col", {28'd0, col}, {28'd0, 4'b1110});
    chk("midrst_stb", {31'd0, key_stb}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_until(5'h0D, 60, found, nstb, stb_at);
    chk("reacq_kd", found, 32);
    chk("reacq_kd_stb", nstb, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
